// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered fill level, programmable almost thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered read.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned ADDRESS_WIDTH          = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD  = 2**ADDRESS_WIDTH - 2,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD = 2,
  parameter int unsigned FWFT                   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   write_increment,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   read_increment,
  output logic [DATA_WIDTH-1:0]  read_data,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   underflow,
  output logic [ADDRESS_WIDTH:0] fill_level
);

  localparam int unsigned DEPTH = 2**ADDRESS_WIDTH;
  localparam int unsigned PTR_W = ADDRESS_WIDTH + 1;

  if (!((ALMOST_EMPTY_THRESHOLD < ALMOST_FULL_THRESHOLD) &&
        (ALMOST_FULL_THRESHOLD <= DEPTH))) begin : g_bad_thresholds
    $error("sync_fifo: thresholds must satisfy AE < AF <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_push;
  logic                  w_pop;
  logic [PTR_W-1:0]      w_level_next;

  // Acceptance uses the registered flags; requests during reset are dropped.
  assign w_push       = write_increment && !r_full  && !reset;
  assign w_pop        = read_increment  && !r_empty && !reset;
  assign w_level_next = r_level + PTR_W'(w_push) - PTR_W'(w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level        <= w_level_next;
      r_full         <= (w_level_next == PTR_W'(DEPTH));
      r_empty        <= (w_level_next == '0);
      r_almost_full  <= (w_level_next >= PTR_W'(ALMOST_FULL_THRESHOLD));
      r_almost_empty <= (w_level_next <= PTR_W'(ALMOST_EMPTY_THRESHOLD));
      if (write_increment && r_full) r_overflow  <= 1'b1;
      if (read_increment && r_empty) r_underflow <= 1'b1;
    end
  end

  // Storage is intentionally not cleared by reset.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[ADDRESS_WIDTH-1:0]] <= write_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign read_data = r_mem[r_rd_ptr[ADDRESS_WIDTH-1:0]];
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_read_data;
    always_ff @(posedge clock) begin
      if (reset) begin
        r_read_data <= '0;
      end else if (w_pop) begin
        r_read_data <= r_mem[r_rd_ptr[ADDRESS_WIDTH-1:0]];
      end
    end
    assign read_data = r_read_data;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign fill_level   = r_level;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: an FWFT instance with default thresholds and a
// registered-read instance with thresholds 3/12 share one randomised stimulus.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] write_data = '0;
  logic          write_increment = 1'b0;
  logic          read_increment = 1'b0;

  logic          a_full, a_afull, a_ovf, a_empty, a_aempty, a_unf;
  logic [DW-1:0] a_rd;
  logic [AW:0]   a_lvl;
  logic          b_full, b_afull, b_ovf, b_empty, b_aempty, b_unf;
  logic [DW-1:0] b_rd;
  logic [AW:0]   b_lvl;

  sync_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(1)) dut_a (
    .clock(clock), .reset(reset), .write_data(write_data),
    .write_increment(write_increment), .full(a_full), .almost_full(a_afull),
    .overflow(a_ovf), .read_increment(read_increment), .read_data(a_rd),
    .empty(a_empty), .almost_empty(a_aempty), .underflow(a_unf),
    .fill_level(a_lvl));

  sync_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_THRESHOLD(12),
              .ALMOST_EMPTY_THRESHOLD(3), .FWFT(0)) dut_b (
    .clock(clock), .reset(reset), .write_data(write_data),
    .write_increment(write_increment), .full(b_full), .almost_full(b_afull),
    .overflow(b_ovf), .read_increment(read_increment), .read_data(b_rd),
    .empty(b_empty), .almost_empty(b_aempty), .underflow(b_unf),
    .fill_level(b_lvl));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus sticky flags and the last popped word.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rd = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            push_ok, pop_ok;

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd  = '0;
    end else begin
      push_ok = write_increment && (exp_q.size() < DEPTH);
      pop_ok  = read_increment && (exp_q.size() > 0);
      if (write_increment && exp_q.size() == DEPTH) m_ovf = 1'b1;
      if (read_increment && exp_q.size() == 0) m_unf = 1'b1;
      if (pop_ok) m_rd = exp_q.pop_front();
      if (push_ok) exp_q.push_back(write_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares both instances against the model away from the active edge.
  initial begin
    int n;
    @(posedge clock);
    forever begin
      @(negedge clock);
      n = exp_q.size();
      chk("a_fill_level", 32'(a_lvl), 32'(n));
      chk("a_full", 32'(a_full), 32'(n == DEPTH));
      chk("a_empty", 32'(a_empty), 32'(n == 0));
      chk("a_almost_full", 32'(a_afull), 32'(n >= 14));
      chk("a_almost_empty", 32'(a_aempty), 32'(n <= 2));
      chk("a_overflow", 32'(a_ovf), 32'(m_ovf));
      chk("a_underflow", 32'(a_unf), 32'(m_unf));
      if (n > 0) chk("a_read_data_head", 32'(a_rd), 32'(exp_q[0]));
      chk("b_fill_level", 32'(b_lvl), 32'(n));
      chk("b_full", 32'(b_full), 32'(n == DEPTH));
      chk("b_empty", 32'(b_empty), 32'(n == 0));
      chk("b_almost_full", 32'(b_afull), 32'(n >= 12));
      chk("b_almost_empty", 32'(b_aempty), 32'(n <= 3));
      chk("b_overflow", 32'(b_ovf), 32'(m_ovf));
      chk("b_underflow", 32'(b_unf), 32'(m_unf));
      chk("b_read_data_popped", 32'(b_rd), 32'(m_rd));
    end
  end

  task automatic cyc(input bit wi, input bit ri, input logic [DW-1:0] d, input bit rst);
    write_increment = wi;
    read_increment  = ri;
    write_data      = d;
    reset           = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int bias;
    do_reset();
    do_reset();

    // Fill to full, then one extra push to trip overflow.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Single word falls through, then is popped.
    do_reset();
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Registered read latency and underflow with read_data hold.
    do_reset();
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    cyc(1'b1, 1'b0, 8'h22, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Simultaneous push+pop at level 5, when full, and when empty.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
    cyc(1'b1, 1'b1, DW'($urandom), 1'b0);
    cyc(1'b1, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b1, 1'b1, DW'($urandom), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Threshold sweep through every fill level up and down.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, '0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0);
    end

    // Reset mid-operation with both requests active.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
    cyc(1'b1, 1'b1, 8'hEE, 1'b1);
    cyc(1'b1, 1'b0, 8'h5C, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Random traffic with drifting push/pop bias and occasional reset.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) bias = int'($urandom_range(15, 85));
      cyc(($urandom_range(99) < 32'(bias)), ($urandom_range(99) >= 32'(bias)),
          DW'($urandom), ($urandom_range(399) == 0));
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
